// File: rtl/fetch_decode_buffer.sv
// Instruction queue between fetch and decode: a circular FIFO of {PC, instr} pairs
// with a valid/ready head, flush-to-empty, and the fetch PC enable (in_ready).
module fetch_decode_buffer #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [31:0]              in_instr,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_instr,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [XLEN-1:0] r_pc_mem    [DEPTH];
   logic [31:0]     r_instr_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic w_in_ready;
   logic w_out_valid;
   logic w_push;
   logic w_pop;

   // in_ready comes only from the registered count, so a pop on a full
   // buffer frees the slot for the following cycle, not this one.
   assign w_in_ready  = (r_count != FULL);
   assign w_out_valid = (r_count != '0);
   assign w_push      = in_valid & w_in_ready & ~flush;
   assign w_pop       = w_out_valid & out_ready & ~flush;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is deliberately left out of reset; count gates its visibility.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= in_pc;
         r_instr_mem[r_wr_ptr] <= in_instr;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
   assign out_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
   assign count     = r_count;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: directed stimulus feeds a scoreboard queue,
// a negedge monitor pops and compares every consumed head entry.
module tb_fetch_decode_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic        flush;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] sb[$];

   fetch_decode_buffer #(.XLEN(32), .DEPTH(4), .NOP_INSTR(32'h0000_0013)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
      .flush(flush), .count(count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs are set at posedge+1, then the task returns at the next posedge+1.
   task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl, input bit acc);
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = ins;
      out_ready = ordy;
      flush     = fl;
      if (fl) sb.delete();
      if (acc) sb.push_back({pc, ins});
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
   endtask

   // Monitor: each head consumed at the coming edge must match the oldest expected pair.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready && !flush) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got pc=%0h instr=%0h expected nothing", out_pc, out_instr);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            if ({out_pc, out_instr} !== e) begin
               n_errors++;
               $display("FAIL sb_order: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                        out_pc, out_instr, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready, 1);
      reset = 1'b1;

      // Idle after reset
      repeat (3) idle(1'b0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_out_instr", out_instr, 32'h0000_0013);
      chk("idle_out_pc",    out_pc, 0);
      chk("idle_in_ready",  in_ready, 1);
      chk("idle_count",     count, 0);

      // Single push, held while decode stalls
      step(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 1'b1);
      chk("one_out_valid", out_valid, 1);
      chk("one_out_pc",    out_pc, 32'h0);
      chk("one_out_instr", out_instr, 32'h0050_0093);
      chk("one_count",     count, 1);
      idle(1'b0);
      idle(1'b0);
      chk("hold_out_instr", out_instr, 32'h0050_0093);
      chk("hold_count",     count, 1);

      // Fill to full, fifth is ignored
      step(1'b1, 32'h4, 32'h0010_0113, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h8, 32'h0020_0193, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hC, 32'h0030_0213, 1'b0, 1'b0, 1'b1);
      chk("full_count",    count, 4);
      chk("full_in_ready", in_ready, 0);
      step(1'b1, 32'h10, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
      chk("full_ignore_count", count, 4);
      chk("full_ignore_head",  out_pc, 32'h0);

      // Drain; the pop-on-full cycle does not accept the offered pair
      step(1'b1, 32'h14, 32'hDEAD_0002, 1'b1, 1'b0, 1'b0);
      chk("drain1_count",    count, 3);
      chk("drain1_in_ready", in_ready, 1);
      idle(1'b1);
      chk("drain2_count", count, 2);
      idle(1'b1);
      idle(1'b1);
      chk("drain_count",     count, 0);
      chk("drain_out_valid", out_valid, 0);
      chk("drain_sb_empty",  sb.size(), 0);

      // Streaming through pointer wrap
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'(i * 4), 32'h1000_0000 | 32'(i * 4), 1'b1, 1'b0, 1'b1);
         chk("stream_count", count, 1);
         chk("stream_lag_pc", out_pc, 32'(i * 4));
      end
      idle(1'b1);
      chk("stream_end_count", count, 0);
      chk("stream_sb_empty",  sb.size(), 0);

      // Flush drops queue and the in-flight pair
      step(1'b1, 32'h30, 32'h2000_0030, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h34, 32'h2000_0034, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h38, 32'h2000_0038, 1'b0, 1'b0, 1'b1);
      chk("preflush_count", count, 3);
      step(1'b1, 32'h40, 32'h2000_0040, 1'b1, 1'b1, 1'b0);
      chk("flush_count",     count, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready",  in_ready, 1);
      idle(1'b1);
      step(1'b1, 32'h44, 32'h2000_0044, 1'b0, 1'b0, 1'b1);
      chk("postflush_pc", out_pc, 32'h44);
      idle(1'b1);

      // Asynchronous reset mid-cycle
      step(1'b1, 32'h50, 32'h3000_0050, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h54, 32'h3000_0054, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      chk("prereset_count", count, 2);
      #3;
      reset = 1'b0;
      sb.delete();
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_count",     count, 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      step(1'b1, 32'h80, 32'h4000_0080, 1'b0, 1'b0, 1'b1);
      chk("postreset_pc",    out_pc, 32'h80);
      chk("postreset_count", count, 1);
      idle(1'b1);
      idle(1'b0);
      chk("final_sb_empty", sb.size(), 0);
      chk("final_count",    count, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Instruction queue between the fetch stage and decode.
- Captures each fetched {PC, instruction} pair in a small circular FIFO and presents the oldest entry to decode through a valid/ready handshake.
- Lets fetch run ahead of a stalled decode, and discards all queued instructions on a flush (taken branch or jump).
- Supplies the enable for the fetch program counter: fetch advances only while this block accepts.

Parameters:
- XLEN, 32, width of the PC field.
- DEPTH, 4, number of entries; a power of two, at least 2.
- NOP_INSTR, 32'h00000013, instruction driven on out_instr when the buffer is empty (addi x0,x0,0).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  fetch presents a valid pair this cycle.
- in_pc  input  XLEN  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  buffer can accept; drives the fetch PC enable.
- out_valid  output  1  head entry is valid.
- out_pc  output  XLEN  PC of the head entry.
- out_instr  output  32  instruction of the head entry, or NOP_INSTR when empty.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  discard all entries.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry register array, write pointer wr_ptr, read pointer rd_ptr (log2 DEPTH bits each, wrap modulo DEPTH), occupancy counter count.
- Reset (reset==0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs then read out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR. Storage contents are not reset.
- Combinational outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_pc and out_instr = entry[rd_ptr] when out_valid; otherwise 0 and NOP_INSTR.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Each rising edge, when flush==0:
  - push: entry[wr_ptr] <= {in_pc, in_instr}; wr_ptr increments.
  - pop: rd_ptr increments.
  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a pushed pair appears at the outputs on the cycle after the push edge. There is no same-cycle bypass; when empty, out_valid stays 0 in the push cycle.
- Full: in_ready=0, so in_valid is ignored. A pop on a full buffer does not open a same-cycle push slot; in_ready depends only on the registered count. in_ready rises the cycle after the pop.
- Empty: out_ready is ignored and count does not underflow.
- Simultaneous push and pop with 0<count<DEPTH: both take effect and count is unchanged.
- Flush has priority over push and pop. At the edge: wr_ptr=0, rd_ptr=0, count=0. The in_valid pair presented in the flush cycle is dropped. Next cycle out_valid=0 and in_ready=1.
- Reset asserted mid-operation: state clears immediately and asynchronously; the buffer restarts empty after reset deasserts.
- Pointer wrap: DEPTH-1 increments to 0 with no gap; FIFO order is preserved across the wrap.
- Handshake rule: the head entry stays stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then in_valid=0 for 3 cycles -> out_valid=0, out_instr=32'h00000013, in_ready=1, count=0.
- Push PC=0x0 instr=0x00500093, out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x00500093, count=1; the value holds while out_ready stays 0.
- out_ready=0, push 4 pairs (PC 0x0,0x4,0x8,0xC) -> count=4, in_ready=0. A fifth in_valid is ignored. Then out_ready=1 for 4 cycles -> out_pc reads 0x0,0x4,0x8,0xC in order; count returns to 0.
- Continuous push and pop for 10 cycles, PC 0x0..0x24 -> count stays 1 and out_pc lags in_pc by one cycle through pointer wrap; no entry is lost or duplicated.
- Buffer at count=3, assert flush with in_valid=1 (PC 0x40) and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; PC 0x40 never appears.
- reset driven low while count=2, mid-cycle -> out_valid=0 and count=0 immediately, without waiting for a clock edge. After reset is released, pushing PC 0x80 yields out_pc=0x80.
